// File: rtl/soc_system_mailbox_master.sv
// Avalon-MM master that polls a 4-word mailbox RAM for GO commands, hands them to
// fabric logic over valid/ready, and posts RESULT, clears CMD, then writes STATUS.
`timescale 1ns/1ps
module soc_system_mailbox_master #(
    parameter int POLL_INTERVAL = 16,
    parameter int READ_LATENCY  = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [1:0]  avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_opcode,
    output logic [31:0] cmd_arg,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    input  logic [31:0] rsp_data,
    output logic        busy,
    output logic [15:0] done_count
);

    localparam logic [15:0] POLL_RELOAD = 16'(POLL_INTERVAL - 1);
    localparam logic [1:0]  LAT_RELOAD  = 2'(READ_LATENCY - 1);

    localparam logic [1:0] ADDR_CMD    = 2'd0;
    localparam logic [1:0] ADDR_ARG    = 2'd1;
    localparam logic [1:0] ADDR_RESULT = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    typedef enum logic [2:0] {
        IDLE, RD_CMD, RD_ARG, ISSUE, WAIT_RSP, WR_RES, WR_CLR, WR_STAT
    } state_t;

    state_t      state_reg;
    logic [15:0] poll_cnt_reg;
    logic        rd_wait_reg;
    logic        rd_have_reg;
    logic [1:0]  lat_cnt_reg;
    logic [31:0] rd_data_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            poll_cnt_reg   <= POLL_RELOAD;
            rd_wait_reg    <= 1'b0;
            rd_have_reg    <= 1'b0;
            lat_cnt_reg    <= 2'd0;
            rd_data_reg    <= 32'h0;
            avm_address    <= 2'd0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= 32'h0;
            avm_byteenable <= 4'h0;
            cmd_valid      <= 1'b0;
            cmd_opcode     <= 8'h0;
            cmd_arg        <= 32'h0;
            rsp_ready      <= 1'b0;
            busy           <= 1'b0;
            done_count     <= 16'h0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (poll_cnt_reg == 16'd0) begin
                        state_reg      <= RD_CMD;
                        busy           <= 1'b1;
                        avm_read       <= 1'b1;
                        avm_address    <= ADDR_CMD;
                        avm_byteenable <= 4'hF;
                    end else begin
                        poll_cnt_reg <= poll_cnt_reg - 16'd1;
                    end
                end

                // Each read goes request -> latency wait -> capture -> decide, one phase at a time.
                RD_CMD, RD_ARG: begin
                    if (avm_read) begin
                        if (!avm_waitrequest) begin
                            avm_read       <= 1'b0;
                            avm_byteenable <= 4'h0;
                            rd_wait_reg    <= 1'b1;
                            lat_cnt_reg    <= LAT_RELOAD;
                        end
                    end else if (rd_wait_reg) begin
                        if (lat_cnt_reg == 2'd0) begin
                            rd_data_reg <= avm_readdata;
                            rd_wait_reg <= 1'b0;
                            rd_have_reg <= 1'b1;
                        end else begin
                            lat_cnt_reg <= lat_cnt_reg - 2'd1;
                        end
                    end else if (rd_have_reg) begin
                        rd_have_reg <= 1'b0;
                        if (state_reg == RD_ARG) begin
                            cmd_arg   <= rd_data_reg;
                            cmd_valid <= 1'b1;
                            state_reg <= ISSUE;
                        end else if (rd_data_reg[31]) begin
                            cmd_opcode     <= rd_data_reg[7:0];
                            state_reg      <= RD_ARG;
                            avm_read       <= 1'b1;
                            avm_address    <= ADDR_ARG;
                            avm_byteenable <= 4'hF;
                        end else begin
                            state_reg    <= IDLE;
                            busy         <= 1'b0;
                            poll_cnt_reg <= POLL_RELOAD;
                        end
                    end
                end

                ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        rsp_ready <= 1'b1;
                        state_reg <= WAIT_RSP;
                    end
                end

                WAIT_RSP: begin
                    if (rsp_valid) begin
                        rsp_ready      <= 1'b0;
                        state_reg      <= WR_RES;
                        avm_write      <= 1'b1;
                        avm_address    <= ADDR_RESULT;
                        avm_writedata  <= rsp_data;
                        avm_byteenable <= 4'hF;
                    end
                end

                WR_RES: begin
                    if (avm_write && !avm_waitrequest) begin
                        avm_write      <= 1'b0;
                        avm_byteenable <= 4'h0;
                        state_reg      <= WR_CLR;
                    end
                end

                // Write strobe drops for one cycle between back-to-back writes.
                WR_CLR: begin
                    if (!avm_write) begin
                        avm_write      <= 1'b1;
                        avm_address    <= ADDR_CMD;
                        avm_writedata  <= 32'h0;
                        avm_byteenable <= 4'hF;
                    end else if (!avm_waitrequest) begin
                        avm_write      <= 1'b0;
                        avm_byteenable <= 4'h0;
                        state_reg      <= WR_STAT;
                    end
                end

                WR_STAT: begin
                    if (!avm_write) begin
                        avm_write      <= 1'b1;
                        avm_address    <= ADDR_STATUS;
                        avm_writedata  <= {done_count + 16'd1, 8'h00, cmd_opcode};
                        avm_byteenable <= 4'hF;
                    end else if (!avm_waitrequest) begin
                        avm_write      <= 1'b0;
                        avm_byteenable <= 4'h0;
                        done_count     <= done_count + 16'd1;
                        state_reg      <= IDLE;
                        busy           <= 1'b0;
                        poll_cnt_reg   <= POLL_RELOAD;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_system_mailbox_master.sv
// Bench for the mailbox master: RAM slave model with stall control, command
// table plus hand-written reset and counter-wrap sequences, queue scoreboard.
`timescale 1ns/1ps
module tb_soc_system_mailbox_master;

    localparam int POLL = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode;
    logic [31:0] cmd_arg;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        busy;
    logic [15:0] done_count;

    soc_system_mailbox_master #(
        .POLL_INTERVAL (POLL),
        .READ_LATENCY  (1)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_opcode      (cmd_opcode),
        .cmd_arg         (cmd_arg),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .busy            (busy),
        .done_count      (done_count)
    );

    always #5 clk = ~clk;

    // RAM slave model: one-cycle read latency, programmable stall per transfer
    logic [31:0] mem [4];
    logic        host_we;
    logic [1:0]  host_wa;
    logic [31:0] host_wd;
    int          stall_n;
    int          stall_ctr = 0;
    logic        force_wait;

    assign avm_waitrequest = force_wait | ((avm_read | avm_write) && (stall_ctr < stall_n));

    always @(posedge clk) begin
        if (host_we)
            mem[host_wa] <= host_wd;
        else if (avm_write && !avm_waitrequest)
            mem[avm_address] <= avm_writedata;
        avm_readdata <= (avm_read && !avm_waitrequest) ? mem[avm_address] : 32'hDEAD_BEEF;
        if ((avm_read || avm_write) && avm_waitrequest)
            stall_ctr <= stall_ctr + 1;
        else
            stall_ctr <= 0;
    end

    typedef struct {
        logic [31:0] cmd;
        logic [31:0] arg;
        logic [31:0] rsp;
        int          ready_dly;
        int          rsp_dly;
        int          stall;
        logic [7:0]  exp_op;
    } vec_t;

    vec_t        vecs [4];
    vec_t        early_vec;
    int          checks = 0;
    int          errors = 0;
    int          issue_cycles;
    int          wait_cycles;
    logic [15:0] exp_cnt;
    logic [39:0] exp_cmd_q [$];
    logic [33:0] exp_wr_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic host_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        host_we = 1'b1;
        host_wa = a;
        host_wd = d;
        @(posedge clk);
        #1;
        host_we = 1'b0;
    endtask

    // Protocol checks and scoreboard pops, sampled on the falling edge.
    task automatic monitor();
        logic        p_bus_hold = 1'b0;
        logic [7:0]  p_bus = 8'h0;
        logic [31:0] p_wd = 32'h0;
        logic        p_cmd_hold = 1'b0;
        logic [40:0] p_cmd = 41'h0;
        logic [39:0] ec;
        logic [33:0] ew;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                p_bus_hold = 1'b0;
                p_cmd_hold = 1'b0;
            end else begin
                check("rd_wr_exclusive", 64'(avm_read & avm_write), 64'd0);
                check("byteenable", 64'(avm_byteenable),
                      64'((avm_read | avm_write) ? 4'hF : 4'h0));
                if (p_bus_hold) begin
                    check("bus_hold_ctrl", 64'({avm_read, avm_write, avm_address, avm_byteenable}),
                          64'(p_bus));
                    check("bus_hold_data", 64'(avm_writedata), 64'(p_wd));
                end
                if (p_cmd_hold)
                    check("cmd_hold", 64'({cmd_valid, cmd_opcode, cmd_arg}), 64'(p_cmd));
                if (cmd_valid && cmd_ready) begin
                    if (exp_cmd_q.size() == 0) begin
                        check("cmd_unexpected", 64'(cmd_valid), 64'd0);
                    end else begin
                        ec = exp_cmd_q.pop_front();
                        check("cmd_payload", 64'({cmd_opcode, cmd_arg}), 64'(ec));
                        $display("cmd accepted opcode %h arg %h", cmd_opcode, cmd_arg);
                    end
                end
                if (avm_write && !avm_waitrequest) begin
                    if (exp_wr_q.size() == 0) begin
                        check("write_unexpected", 64'(avm_write), 64'd0);
                    end else begin
                        ew = exp_wr_q.pop_front();
                        check("write_order", 64'({avm_address, avm_writedata}), 64'(ew));
                        $display("bus write addr %0d data %h", avm_address, avm_writedata);
                    end
                end
                issue_cycles += int'(cmd_valid);
                wait_cycles  += int'(rsp_ready);
                p_bus_hold = (avm_read | avm_write) & avm_waitrequest;
                p_bus      = {avm_read, avm_write, avm_address, avm_byteenable};
                p_wd       = avm_writedata;
                p_cmd_hold = cmd_valid & ~cmd_ready;
                p_cmd      = {cmd_valid, cmd_opcode, cmd_arg};
            end
        end
    endtask

    // One idle poll period: read, latency, decide, then POLL idle cycles.
    task automatic idle_window(input logic [31:0] cmd_word);
        int n;
        int busy_n;
        logic seen_valid;
        host_write(2'd0, cmd_word);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!avm_read && n < 50);
        check("poll_read_addr", 64'({avm_read, avm_address}), 64'(3'b100));
        busy_n = int'(busy);
        seen_valid = cmd_valid;
        for (int i = 1; i < POLL + 3; i++) begin
            @(negedge clk);
            busy_n += int'(busy);
            seen_valid |= cmd_valid;
        end
        @(negedge clk);
        check("poll_period", 64'(avm_read), 64'd1);
        check("poll_busy_cycles", 64'(busy_n), 64'd3);
        check("poll_no_cmd", 64'(seen_valid), 64'd0);
        $display("idle poll cmd %h busy cycles %0d", cmd_word, busy_n);
    endtask

    task automatic run_cmd(input vec_t v, input bit tied);
        int n;
        logic [31:0] st;
        st = {exp_cnt + 16'd1, 8'h00, v.exp_op};
        exp_cmd_q.push_back({v.exp_op, v.arg});
        exp_wr_q.push_back({2'd2, v.rsp});
        exp_wr_q.push_back({2'd0, 32'h0});
        exp_wr_q.push_back({2'd3, st});
        stall_n = v.stall;
        if (tied) begin
            cmd_ready = 1'b1;
            rsp_valid = 1'b1;
            rsp_data  = v.rsp;
        end
        host_write(2'd1, v.arg);
        issue_cycles = 0;
        wait_cycles  = 0;
        host_write(2'd0, v.cmd);
        if (!tied) begin
            n = 0;
            while (!cmd_valid && n < 300) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("cmd_valid_seen", 64'(cmd_valid), 64'd1);
            repeat (v.ready_dly) begin
                @(posedge clk);
                #1;
            end
            cmd_ready = 1'b1;
            @(posedge clk);
            #1;
            cmd_ready = 1'b0;
            repeat (v.rsp_dly) begin
                @(posedge clk);
                #1;
            end
            rsp_valid = 1'b1;
            rsp_data  = v.rsp;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!rsp_ready && n < 300);
            @(posedge clk);
            #1;
            rsp_valid = 1'b0;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_wr_q.size() != 0 || busy) && n < 3000);
        check("cmd_complete", 64'(exp_wr_q.size()), 64'd0);
        exp_wr_q.delete();
        exp_cmd_q.delete();
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        check("done_count", 64'(done_count), 64'(exp_cnt));
        check("mem_result", 64'(mem[2]), 64'(v.rsp));
        check("mem_cmd_cleared", 64'(mem[0]), 64'd0);
        check("mem_status", 64'(mem[3]), 64'(st));
        check("issue_cycles", 64'(issue_cycles), 64'(v.ready_dly + 1));
        check("wait_rsp_cycles", 64'(wait_cycles), 64'(v.rsp_dly + 1));
        $display("command %h arg %h rsp %h status %h count %0d", v.cmd, v.arg, v.rsp, mem[3], done_count);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n    = 1'b0;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_data   = 32'h0;
        host_we    = 1'b0;
        host_wa    = 2'd0;
        host_wd    = 32'h0;
        stall_n    = 0;
        force_wait = 1'b0;
        exp_cnt    = 16'h0;

        vecs[0]   = '{32'h8000_0005, 32'h1234_5678, 32'hCAFE_F00D, 0, 0, 0, 8'h05};
        vecs[1]   = '{32'h8000_0005, 32'h1234_5678, 32'hCAFE_F00D, 10, 7, 3, 8'h05};
        vecs[2]   = '{32'hFFFF_FFAA, 32'hDEAD_0001, 32'h0BAD_CAFE, 2, 1, 1, 8'hAA};
        vecs[3]   = '{32'h8000_0100, 32'h0000_0000, 32'hFFFF_FFFF, 0, 3, 2, 8'h00};
        early_vec = '{32'h8000_0033, 32'h0000_BEEF, 32'h7777_1111, 0, 0, 0, 8'h33};

        fork
            monitor();
        join_none

        for (int i = 0; i < 4; i++) host_write(2'(i), 32'h0);
        #1;
        check("reset_bus", 64'({avm_read, avm_write, avm_address, avm_byteenable}), 64'd0);
        check("reset_handshake", 64'({cmd_valid, rsp_ready, busy}), 64'd0);
        check("reset_payload", 64'({cmd_opcode, cmd_arg}), 64'd0);
        check("reset_writedata", 64'(avm_writedata), 64'd0);
        check("reset_done_count", 64'(done_count), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        idle_window(32'h0000_0000);
        idle_window(32'h0000_0000);
        idle_window(32'h7FFF_FFFF);
        host_write(2'd0, 32'h0);

        for (int i = 0; i < 4; i++) run_cmd(vecs[i], 1'b0);
        run_cmd(early_vec, 1'b1);

        // Reset while the CMD-clear write is stalled.
        stall_n   = 3;
        cmd_ready = 1'b1;
        rsp_valid = 1'b1;
        rsp_data  = 32'h5555_AAAA;
        exp_cmd_q.push_back({8'h05, 32'h0000_0042});
        exp_wr_q.push_back({2'd2, 32'h5555_AAAA});
        host_write(2'd1, 32'h0000_0042);
        host_write(2'd0, 32'h8000_0005);
        n = 0;
        while (!(avm_write && avm_address == 2'd0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reach_wr_clr", 64'(avm_write && avm_address == 2'd0), 64'd1);
        force_wait = 1'b1;
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_reset_bus", 64'({avm_read, avm_write, avm_address, avm_byteenable}), 64'd0);
        check("async_reset_handshake", 64'({cmd_valid, rsp_ready, busy}), 64'd0);
        check("async_reset_payload", 64'({cmd_opcode, cmd_arg}), 64'd0);
        check("async_reset_writedata", 64'(avm_writedata), 64'd0);
        check("async_reset_count", 64'(done_count), 64'd0);
        exp_wr_q.delete();
        exp_cmd_q.delete();
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        force_wait = 1'b0;
        stall_n    = 0;
        host_write(2'd0, 32'h0);
        exp_cnt = 16'h0;
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(avm_read || avm_write) && n < 50);
        check("post_reset_delay", 64'(n), 64'(POLL));
        check("post_reset_first_access", 64'({avm_read, avm_write, avm_address}), 64'(4'b1000));
        $display("reset release first access after %0d cycles", n);

        // Counter wrap: preload the completed-command count.
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        force dut.done_count = 16'hFFFF;
        @(negedge clk);
        release dut.done_count;
        @(negedge clk);
        check("preload_count", 64'(done_count), 64'hFFFF);
        exp_cnt = 16'hFFFF;
        run_cmd(vecs[0], 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/soc_system_mailbox_master.md
Name: soc_system_mailbox_master

Overview:
- Avalon-MM master that drives the host-facing slave port of the 4-word, 32-bit dual-port RAM and uses it as a command mailbox with the HPS.
- Polls word 0 for a GO command and reads the argument in word 1.
- Hands opcode and argument to fabric logic over a valid/ready pair, then writes the fabric response to word 2, clears word 0 and posts status to word 3.
- Sits in the FPGA fabric, between the RAM's second slave port and a user compute block.

Parameters:
- POLL_INTERVAL, 16: idle cycles between command polls; legal range 1..65535.
- READ_LATENCY, 1: cycles from read acceptance to valid avm_readdata; legal range 1..3.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- avm_address  out  2  word address: 0=CMD, 1=ARG, 2=RESULT, 3=STATUS.
- avm_read  out  1  read request.
- avm_write  out  1  write request.
- avm_writedata  out  32  write data.
- avm_byteenable  out  4  always 4'hF while read or write is asserted, else 4'h0.
- avm_readdata  in  32  read data.
- avm_waitrequest  in  1  slave stall; tie to 0 for the on-chip RAM.
- cmd_valid  out  1  command available to fabric.
- cmd_ready  in  1  fabric accepts command.
- cmd_opcode  out  8  CMD[7:0].
- cmd_arg  out  32  ARG word.
- rsp_valid  in  1  fabric result available.
- rsp_ready  out  1  block accepts result.
- rsp_data  in  32  fabric result.
- busy  out  1  high in every state except IDLE.
- done_count  out  16  number of completed commands; wraps 16'hFFFF -> 0.

Behaviour:
- Reset (asynchronous, immediate, any state):
  - All outputs are 0; state is IDLE.
  - Poll counter loads POLL_INTERVAL-1; done_count is 0.
  - A transfer in flight is abandoned. No partial write is retried after reset release.
- CMD word format: bit31 = GO; bits 7:0 = opcode; other bits are ignored.
- States:
  - IDLE: counter decrements each cycle. At 0, go to RD_CMD. On every entry, the counter reloads POLL_INTERVAL-1.
  - RD_CMD: avm_read=1, address 0, held until waitrequest=0. The data-valid cycle is READ_LATENCY cycles after that accept; capture then.
    - If readdata[31]=0: go to IDLE.
    - Else: latch opcode and go to RD_ARG.
  - RD_ARG: same read protocol on address 1. Latch cmd_arg, then go to ISSUE.
  - ISSUE: cmd_valid=1 with opcode and arg stable. Leave on the cycle where cmd_valid & cmd_ready are both high; go to WAIT_RSP.
  - WAIT_RSP: rsp_ready=1. On rsp_valid & rsp_ready, latch rsp_data and go to WR_RES.
  - WR_RES: avm_write=1, address 2, writedata = latched result, held until waitrequest=0; then go to WR_CLR.
  - WR_CLR: write 32'h0 to address 0; then go to WR_STAT.
  - WR_STAT: write {done_count+1, 8'h00, opcode} to address 3.
    - On accept, done_count increments and the state goes to IDLE.
- Ordering: RESULT is written before CMD is cleared, and STATUS is written last. This ordering is mandatory: the host may read RESULT as soon as it sees GO=0.
- Protocol rules:
  - Never assert avm_read and avm_write together.
  - At most one outstanding read.
  - Address, writedata and byteenable stay stable while waitrequest=1.
  - avm_read/avm_write drop the cycle after acceptance.
- Handshakes:
  - cmd_valid, once high, stays high with stable data until accepted.
  - rsp_ready is high only in WAIT_RSP.
  - rsp_valid outside WAIT_RSP is ignored.
- Simultaneous events: cmd_ready already high on entry to ISSUE completes the handshake in that first cycle. rsp_valid arriving the cycle after is accepted normally.
- A host write to CMD while busy is not observed until the next poll. Its GO is overwritten by WR_CLR; software must wait for GO=0 before posting.

Test Plan:
- Idle poll: CMD=32'h0000_0000, POLL_INTERVAL=4.
  - Expect one read of address 0 every 4+READ_LATENCY+2 cycles.
  - No cmd_valid; busy only during the read.
- Single command: CMD=32'h8000_0005, ARG=32'h1234_5678; fabric returns 32'hCAFE_F00D.
  - Expect cmd_opcode=8'h05 and cmd_arg=32'h1234_5678.
  - Then writes in order: addr2=32'hCAFE_F00D, addr0=0, addr3=32'h0001_0005.
  - done_count=1.
- Backpressure: cmd_ready low 10 cycles, rsp_valid delayed 7 cycles, avm_waitrequest high 3 cycles on each transfer.
  - Outputs stay stable throughout; same final memory contents as the single-command test.
- Counter wrap: preload 65535 completed commands (force or loop), then run one more.
  - STATUS[31:16]=16'h0000; done_count=0.
- Reset mid-operation: assert reset_n=0 during WR_CLR with waitrequest=1.
  - All outputs go to 0 asynchronously.
  - After release, the first bus activity is a CMD read POLL_INTERVAL cycles later.
- Early ready: cmd_ready tied 1 and rsp_valid tied 1.
  - Command completes with exactly one cycle in ISSUE and one in WAIT_RSP.
